ldtu_tx_buffer: RTL and testbench

LDTU_TX_BUFFER -- requirements
Module: ldtu_tx_buffer

---
 rtl/ldtu_tx_buffer.sv | 113 +++++++++++
 tb/tb_ldtu_tx_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ldtu_tx_buffer
//  Purpose  : 32-bit transmit FIFO between the encoder (normal or fallback
//             stream) and the serializer. The serializer pulls one word per
//             ser_ready strobe. When nothing is buffered, IDLE_WORD is
//             presented instead and tx_idle is raised.
//  Options  : LDTU_TX_OVF_CNT_EN adds an 8-bit saturating count of dropped
//             words, output on ovf_count.
//  Revision : 1.0  initial release
// ============================================================================
module ldtu_tx_buffer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] IDLE_WORD = 32'hEAAA_AAAA
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     fallback,
  input  logic [31:0]              DATA_32,
  input  logic                     Load,
  input  logic [31:0]              DATA_32_FB,
  input  logic                     Load_FB,
  input  logic                     ser_ready,
  output logic [31:0]              tx_data,
  output logic                     tx_idle,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
`ifdef LDTU_TX_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          wr_req;
  logic [31:0]   wr_data;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Select the active write source and decide push/pop/drop for this edge.
  // A pop on a full FIFO frees the slot that the concurrent write takes.
  always_comb begin
    wr_req  = fallback ? Load_FB : Load;
    wr_data = fallback ? DATA_32_FB : DATA_32;
    empty   = (fill_level == '0);
    full    = (fill_level == FULL_LVL);
    pop     = !reset && ser_ready && !empty;
    push    = !reset && wr_req && (!full || pop);
    drop    = !reset && wr_req && full && !pop;
  end

  // Storage array; not reset, stale contents are unreachable after a reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, sticky overflow and the serializer output word.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      tx_data    <= IDLE_WORD;
      tx_idle    <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
        tx_idle <= 1'b0;
      end else if (ser_ready) begin
        tx_data <= IDLE_WORD;
        tx_idle <= 1'b1;
      end
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FW'(1);
        2'b01:   fill_level <= fill_level - FW'(1);
        default: fill_level <= fill_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef LDTU_TX_OVF_CNT_EN
  // Count dropped words, saturating at 255; only reset clears it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ovf_count <= 8'd0;
    end else if (drop && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldtu_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldtu_tx_buffer
//  Purpose  : Self-checking bench for ldtu_tx_buffer: queue-based reference
//             model, per-cycle compare process, directed literal scenarios
//             and a randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ldtu_tx_buffer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] IDLE  = 32'hEAAA_AAAA;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        fallback = 1'b0;
  logic [31:0] DATA_32 = '0;
  logic        Load = 1'b0;
  logic [31:0] DATA_32_FB = '0;
  logic        Load_FB = 1'b0;
  logic        ser_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_idle;
  logic [3:0]  fill_level;
  logic        overflow;
`ifdef LDTU_TX_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  ldtu_tx_buffer #(.DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .fallback   (fallback),
    .DATA_32    (DATA_32),
    .Load       (Load),
    .DATA_32_FB (DATA_32_FB),
    .Load_FB    (Load_FB),
    .ser_ready  (ser_ready),
    .tx_data    (tx_data),
    .tx_idle    (tx_idle),
    .fill_level (fill_level),
    .overflow   (overflow)
`ifdef LDTU_TX_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_data = IDLE;
  logic        m_idle = 1'b1;
  logic        m_ovf  = 1'b0;
  int          m_cnt  = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Apply one edge of stimulus, then advance the model for that edge.
  task automatic cyc(input logic rs, input logic fb, input logic ld, input logic [31:0] d,
                     input logic ldfb, input logic [31:0] dfb, input logic sr);
    reset = rs; fallback = fb; Load = ld; DATA_32 = d;
    Load_FB = ldfb; DATA_32_FB = dfb; ser_ready = sr;
    @(posedge CLK);
    if (rs) begin
      q.delete();
      m_data = IDLE; m_idle = 1'b1; m_ovf = 1'b0; m_cnt = 0;
      chk_en = 1'b1;
    end else begin
      if (sr) begin
        if (q.size() > 0) begin
          m_data = q.pop_front(); m_idle = 1'b0;
        end else begin
          m_data = IDLE; m_idle = 1'b1;
        end
      end
      if (fb ? ldfb : ld) begin
        if (q.size() < DEPTH) q.push_back(fb ? dfb : d);
        else begin
          m_ovf = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic idle_cyc(input logic sr);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, sr);
  endtask

  task automatic load(input logic [31:0] d, input logic sr);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0, 32'h0, sr);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("tx_data", tx_data, m_data);
      check("tx_idle", {31'b0, tx_idle}, {31'b0, m_idle});
      check("fill_level", {28'b0, fill_level}, 32'(q.size()));
      check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef LDTU_TX_OVF_CNT_EN
      check("ovf_count", {24'b0, ovf_count}, 32'(m_cnt));
`endif
    end
  end

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("rst_data", tx_data, 32'hEAAA_AAAA);
    check("rst_idle", {31'b0, tx_idle}, 32'd1);
    check("rst_fill", {28'b0, fill_level}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);

    // Serializer pulls with nothing buffered
    for (int i = 0; i < 3; i++) begin
      idle_cyc(1'b1);
      check("empty_pull_data", tx_data, 32'hEAAA_AAAA);
      check("empty_pull_fill", {28'b0, fill_level}, 32'd0);
    end

    // Three words then four pulls
    load(32'h1111_1111, 1'b0);
    load(32'h2222_2222, 1'b0);
    load(32'h3333_3333, 1'b0);
    check("three_fill", {28'b0, fill_level}, 32'd3);
    idle_cyc(1'b1); check("rd1", tx_data, 32'h1111_1111);
    check("rd1_idle", {31'b0, tx_idle}, 32'd0);
    idle_cyc(1'b1); check("rd2", tx_data, 32'h2222_2222);
    idle_cyc(1'b1); check("rd3", tx_data, 32'h3333_3333);
    idle_cyc(1'b1); check("rd4", tx_data, 32'hEAAA_AAAA);
    check("rd4_idle", {31'b0, tx_idle}, 32'd1);

    // Ten writes into depth 8
    for (int i = 0; i < 10; i++) load(32'h0000_0100 + 32'(i), 1'b0);
    check("ovf_fill", {28'b0, fill_level}, 32'd8);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
`ifdef LDTU_TX_OVF_CNT_EN
    check("ovf_cnt2", {24'b0, ovf_count}, 32'd2);
`endif
    for (int i = 0; i < 8; i++) begin
      idle_cyc(1'b1);
      check("ovf_drain", tx_data, 32'h0000_0100 + 32'(i));
    end
    idle_cyc(1'b1);
    check("ovf_drain_end", tx_data, 32'hEAAA_AAAA);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("ovf_cleared", {31'b0, overflow}, 32'd0);

    // Full FIFO with simultaneous write and pull
    for (int i = 0; i < 8; i++) load(32'h0000_0A00 + 32'(i), 1'b0);
    load(32'h0000_BEEF, 1'b1);
    check("full_rw_fill", {28'b0, fill_level}, 32'd8);
    check("full_rw_ovf", {31'b0, overflow}, 32'd0);
    check("full_rw_head", tx_data, 32'h0000_0A00);
    for (int i = 1; i < 8; i++) idle_cyc(1'b1);
    check("full_rw_prev", tx_data, 32'h0000_0A07);
    idle_cyc(1'b1);
    check("full_rw_last", tx_data, 32'h0000_BEEF);

    // Fallback source selection, both strobes on the same edge
    cyc(1'b0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b1, 32'hF000_0001, 1'b0);
    check("fb_fill", {28'b0, fill_level}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("fb_word", tx_data, 32'hF000_0001);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("fb_then_idle", tx_data, 32'hEAAA_AAAA);

    // Write on an empty pull is stored, not bypassed
    load(32'h0000_C0DE, 1'b1);
    check("nobypass_data", tx_data, 32'hEAAA_AAAA);
    check("nobypass_fill", {28'b0, fill_level}, 32'd1);
    idle_cyc(1'b1);
    check("nobypass_read", tx_data, 32'h0000_C0DE);

    // Reset mid-operation discards buffered words
    for (int i = 0; i < 5; i++) load(32'h0000_0500 + 32'(i), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("midrst_fill", {28'b0, fill_level}, 32'd0);
    check("midrst_idle", {31'b0, tx_idle}, 32'd1);
    idle_cyc(1'b1);
    check("midrst_pull", tx_data, 32'hEAAA_AAAA);

    // Randomized phase with varying write/read pressure
    for (int seg = 0; seg < 8; seg++) begin
      int wp = $urandom_range(20, 90);
      int rp = $urandom_range(20, 90);
      for (int i = 0; i < 400; i++) begin
        cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < wp), $urandom,
            ($urandom_range(0, 99) < wp), $urandom,
            ($urandom_range(0, 99) < rp));
      end
    end

    idle_cyc(1'b0);
    @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
